// File: rtl/axi_stream_if.sv
// AXI-stream channel bundle: data, valid, last and the back-pressure ready.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_write_vector.sv
// Serializes a run-time-length bit vector onto an AXI-stream master,
// AXI_DATA_WIDTH bits per beat, with tlast on the final beat of a set.
module axi_write_vector #(
    parameter int MAX_VEC_LENGTH = 8,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int WRITE_DIR      = 0,   // 0 = DIR__RIGHT, 1 = DIR__LEFT
    parameter int VEC_LENGTH_W   = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [VEC_LENGTH_W-1:0]   vec_length,
    input  logic [MAX_VEC_LENGTH-1:0] vec,
    input  logic                      last,
    output logic                      busy,
    output logic                      ready,
    axi_stream_if.master              data_out
);

    localparam int DIR__RIGHT = 0;
    localparam int DIR__LEFT  = 1;

    localparam int W         = AXI_DATA_WIDTH;
    localparam int MAX_BEATS = (MAX_VEC_LENGTH + W - 1) / W;
    localparam int CNT_W     = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
    // Wide enough for len, k*W+i and a sign bit, so len-1-k*W-i never wraps
    // into a positive value even when W is larger than the vector.
    localparam int IW        = VEC_LENGTH_W + CNT_W + $clog2(W + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_reg,  state_next;
    logic [MAX_VEC_LENGTH-1:0] vec_reg,    vec_next;
    logic [VEC_LENGTH_W-1:0]   len_reg,    len_next;
    logic                      last_reg,   last_next;
    logic [CNT_W-1:0]          beats_reg,  beats_next;
    logic [CNT_W-1:0]          beat_reg,   beat_next;
    logic [W-1:0]              tdata_reg,  tdata_next;
    logic                      tvalid_reg, tvalid_next;
    logic                      tlast_reg,  tlast_next;
    logic                      ready_reg,  ready_next;
    logic                      busy_reg,   busy_next;

    logic [VEC_LENGTH_W-1:0]   len_clamped;
    logic [CNT_W-1:0]          beats_in;
    logic [CNT_W-1:0]          beat_inc;

    // Build beat k of vector v with length l; positions outside 0..l-1 read as 0.
    function automatic logic [W-1:0] pack_beat(
        input logic [MAX_VEC_LENGTH-1:0] v,
        input logic [VEC_LENGTH_W-1:0]   l,
        input logic [CNT_W-1:0]          k
    );
        logic [IW-1:0]             base;
        logic [IW-1:0]             len_x;
        logic [IW-1:0]             idx;
        logic [MAX_VEC_LENGTH-1:0] sh;
        pack_beat = '0;
        len_x     = IW'(l);
        base      = IW'(k) * IW'(W);
        for (int i = 0; i < W; i++) begin
            if (WRITE_DIR == DIR__RIGHT) begin
                idx = base + IW'(i);
                sh  = v >> idx;
                if (idx < len_x) begin
                    pack_beat[i] = sh[0];
                end
            end else begin
                // Negative index (sign bit set) means below element 0.
                idx = len_x - IW'(1) - base - IW'(i);
                sh  = v >> idx;
                if (!idx[IW-1]) begin
                    pack_beat[W-1-i] = sh[0];
                end
            end
        end
    endfunction

    // Number of beats for length l, never fewer than one.
    function automatic logic [CNT_W-1:0] beat_count(input logic [VEC_LENGTH_W-1:0] l);
        logic [IW-1:0] n;
        n = (IW'(l) + IW'(W - 1)) / IW'(W);
        if (n == '0) begin
            beat_count = CNT_W'(1);
        end else begin
            beat_count = CNT_W'(n);
        end
    endfunction

    assign len_clamped = (vec_length > VEC_LENGTH_W'(MAX_VEC_LENGTH))
                       ? VEC_LENGTH_W'(MAX_VEC_LENGTH) : vec_length;
    assign beats_in    = beat_count(len_clamped);
    assign beat_inc    = beat_reg + CNT_W'(1);

    // State and all outputs are registered; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            vec_reg    <= '0;
            len_reg    <= '0;
            last_reg   <= 1'b0;
            beats_reg  <= '0;
            beat_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            vec_reg    <= vec_next;
            len_reg    <= len_next;
            last_reg   <= last_next;
            beats_reg  <= beats_next;
            beat_reg   <= beat_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            ready_reg  <= ready_next;
            busy_reg   <= busy_next;
        end
    end

    // Next-state logic: capture on start, advance a beat per handshake, pulse ready.
    always_comb begin
        state_next  = state_reg;
        vec_next    = vec_reg;
        len_next    = len_reg;
        last_next   = last_reg;
        beats_next  = beats_reg;
        beat_next   = beat_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        ready_next  = 1'b0;
        busy_next   = busy_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    vec_next    = vec;
                    len_next    = len_clamped;
                    last_next   = last;
                    beats_next  = beats_in;
                    beat_next   = '0;
                    tdata_next  = pack_beat(vec, len_clamped, '0);
                    tlast_next  = last && (beats_in == CNT_W'(1));
                    tvalid_next = 1'b1;
                    busy_next   = 1'b1;
                    state_next  = S_SEND;
                end
            end
            S_SEND: begin
                if (tvalid_reg && data_out.tready) begin
                    if (beat_reg == beats_reg - CNT_W'(1)) begin
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        tdata_next  = '0;
                        ready_next  = 1'b1;
                        state_next  = S_DONE;
                    end else begin
                        beat_next  = beat_inc;
                        tdata_next = pack_beat(vec_reg, len_reg, beat_inc);
                        tlast_next = last_reg && (beat_inc == beats_reg - CNT_W'(1));
                    end
                end
            end
            S_DONE: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign data_out.tdata  = tdata_reg;
    assign data_out.tvalid = tvalid_reg;
    assign data_out.tlast  = tlast_reg;
    assign ready           = ready_reg;
    assign busy            = busy_reg;

endmodule
